// File: rtl/cbfp_pkg.sv
// -----------------------------------------------------------------------------
// cbfp_pkg
// Shared widths, lane-array types, index/shift types and the framing FSM
// encoding for the CBFP de-normaliser (cbfp_denorm) and its lane shifter.
// calc_sh() turns a block scaling index into the signed per-lane shift:
// positive values shift left and negative values shift right.
// -----------------------------------------------------------------------------
package cbfp_pkg;

    localparam int CNT_SIZE      = 5;   // width of the scaling index (zero count)
    localparam int ARRAY_SIZE    = 16;  // lanes per beat
    localparam int DIN_SIZE      = 11;  // signed input mantissa width
    localparam int DOUT_SIZE     = 16;  // signed output width
    localparam int BEATS_PER_BLK = 4;   // valid beats per CBFP block
    localparam int SHIFT_REF     = 6;   // index value that gives unity gain

    typedef logic [CNT_SIZE-1:0]                  idx_t;
    typedef logic signed [CNT_SIZE:0]             sh_t;
    typedef logic [ARRAY_SIZE-1:0][DIN_SIZE-1:0]  mant_arr_t;
    typedef logic [ARRAY_SIZE-1:0][DOUT_SIZE-1:0] dout_arr_t;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        IN_BLK = 1'b1
    } fsm_state_t;

    // Signed shift amount for a block index.
    // The index is zero-extended so that every 5-bit index value is treated as positive.
    function automatic sh_t calc_sh(input idx_t idx);
        return sh_t'(SHIFT_REF) - sh_t'({1'b0, idx});
    endfunction

endpackage

// File: rtl/cbfp_lane_shift.sv
// -----------------------------------------------------------------------------
// cbfp_lane_shift
// Combinational shift, round and saturate for one lane.
//   din   : signed DIN_SIZE mantissa
//   sh    : signed shift (>=0 shifts left, <0 shifts right arithmetically)
//   value : signed DOUT_SIZE result, clipped to the output range
//   sat   : high when the clip was applied
// Build option: the macro CBFP_DENORM_ROUND_EN makes right shifts round half-up.
// Without the macro, right shifts truncate (floor).
// -----------------------------------------------------------------------------
module cbfp_lane_shift
    import cbfp_pkg::*;
(
    input  logic signed [DIN_SIZE-1:0]  din,
    input  sh_t                         sh,
    output logic signed [DOUT_SIZE-1:0] value,
    output logic                        sat
);

    // The intermediate width must hold the largest left shift (2^CNT_SIZE - 1).
    // It must also exceed the largest right shift.
    // With that width, an oversize right shift settles to 0 or -1.
    localparam int WIDE = DIN_SIZE + (1 << CNT_SIZE) + 1;

    localparam logic signed [WIDE-1:0] SAT_MAX =
        {{(WIDE-DOUT_SIZE+1){1'b0}}, {(DOUT_SIZE-1){1'b1}}};
    localparam logic signed [WIDE-1:0] SAT_MIN =
        {{(WIDE-DOUT_SIZE+1){1'b1}}, {(DOUT_SIZE-1){1'b0}}};

    logic signed [WIDE-1:0] ext;
    logic signed [WIDE-1:0] rnd;
    logic signed [WIDE-1:0] shifted;
    logic        [CNT_SIZE:0] rsh;

    always_comb begin
        ext     = {{(WIDE-DIN_SIZE){din[DIN_SIZE-1]}}, din};
        rsh     = -sh;
        rnd     = '0;
        shifted = '0;
        if (!sh[CNT_SIZE]) begin
            shifted = ext <<< sh[CNT_SIZE-1:0];
        end else begin
`ifdef CBFP_DENORM_ROUND_EN
            // Half an LSB of the result, added before the shift.
            // rsh is at least 1 whenever this branch is taken.
            rnd = WIDE'(1) << (rsh - 1'b1);
`endif
            shifted = (ext + rnd) >>> rsh;
        end

        value = shifted[DOUT_SIZE-1:0];
        sat   = 1'b0;
        if (shifted > SAT_MAX) begin
            value = SAT_MAX[DOUT_SIZE-1:0];
            sat   = 1'b1;
        end else if (shifted < SAT_MIN) begin
            value = SAT_MIN[DOUT_SIZE-1:0];
            sat   = 1'b1;
        end
    end

endmodule

// File: rtl/cbfp_denorm.sv
// -----------------------------------------------------------------------------
// cbfp_denorm
// This is the output-side counterpart of the CBFP normaliser.
// It restores 16-lane re/im mantissa beats to a common 16-bit fixed-point scale.
// The restore uses the per-block scaling indices produced by the normaliser.
// Blocks are framed as BEATS_PER_BLK valid beats. Gaps in valid_in are allowed.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   valid_in            : input beat valid
//   blk_start_in        : first beat of a block (qualified by valid_in)
//   idx_re_in/idx_im_in : block indices, sampled on the start beat
//   din_re/din_im       : ARRAY_SIZE x DIN_SIZE signed mantissas
//   valid_out           : output beat valid (2 cycles after an accepted beat)
//   blk_start_out       : first output beat of a block
//   dout_re/dout_im     : ARRAY_SIZE x DOUT_SIZE denormalised samples
//   sat_out             : some lane of this output beat was clipped
//   err_frame           : one-cycle framing-error pulse
// Build option: the macro CBFP_DENORM_ROUND_EN enables round-half-up right shifts.
// -----------------------------------------------------------------------------
module cbfp_denorm
    import cbfp_pkg::*;
(
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 valid_in,
    input  logic                                 blk_start_in,
    input  logic [CNT_SIZE-1:0]                  idx_re_in,
    input  logic [CNT_SIZE-1:0]                  idx_im_in,
    input  logic [ARRAY_SIZE-1:0][DIN_SIZE-1:0]  din_re,
    input  logic [ARRAY_SIZE-1:0][DIN_SIZE-1:0]  din_im,
    output logic                                 valid_out,
    output logic                                 blk_start_out,
    output logic [ARRAY_SIZE-1:0][DOUT_SIZE-1:0] dout_re,
    output logic [ARRAY_SIZE-1:0][DOUT_SIZE-1:0] dout_im,
    output logic                                 sat_out,
    output logic                                 err_frame
);

    localparam int BEAT_W = (BEATS_PER_BLK > 1) ? $clog2(BEATS_PER_BLK) : 1;

    // ---------------- framing FSM ----------------
    fsm_state_t        state_reg, state_next;
    logic [BEAT_W-1:0] beat_cnt_reg, beat_cnt_next;
    idx_t              idx_re_reg, idx_re_next;
    idx_t              idx_im_reg, idx_im_next;
    logic              accept;
    logic              err_next;

    always_comb begin
        state_next    = state_reg;
        beat_cnt_next = beat_cnt_reg;
        idx_re_next   = idx_re_reg;
        idx_im_next   = idx_im_reg;
        accept        = 1'b0;
        err_next      = 1'b0;
        if (valid_in) begin
            if (blk_start_in) begin
                // A start beat inside a block abandons the old block and restarts.
                accept      = 1'b1;
                err_next    = (state_reg == IN_BLK);
                idx_re_next = idx_re_in;
                idx_im_next = idx_im_in;
                if (BEATS_PER_BLK == 1) begin
                    state_next    = IDLE;
                    beat_cnt_next = '0;
                end else begin
                    state_next    = IN_BLK;
                    beat_cnt_next = BEAT_W'(1);
                end
            end else if (state_reg == IN_BLK) begin
                accept = 1'b1;
                if (beat_cnt_reg == BEAT_W'(BEATS_PER_BLK - 1)) begin
                    state_next    = IDLE;
                    beat_cnt_next = '0;
                end else begin
                    beat_cnt_next = beat_cnt_reg + 1'b1;
                end
            end else begin
                // An orphan beat outside a block is dropped.
                err_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            beat_cnt_reg <= '0;
            idx_re_reg   <= '0;
            idx_im_reg   <= '0;
        end else begin
            state_reg    <= state_next;
            beat_cnt_reg <= beat_cnt_next;
            idx_re_reg   <= idx_re_next;
            idx_im_reg   <= idx_im_next;
        end
    end

    // On the start beat, the fresh indices apply to that same beat.
    idx_t cur_idx_re, cur_idx_im;
    assign cur_idx_re = blk_start_in ? idx_re_in : idx_re_reg;
    assign cur_idx_im = blk_start_in ? idx_im_in : idx_im_reg;

    // ---------------- stage 1: operands ----------------
    logic      s1_valid_reg;
    logic      s1_start_reg;
    mant_arr_t s1_re_reg, s1_im_reg;
    sh_t       s1_sh_re_reg, s1_sh_im_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_reg <= 1'b0;
            s1_start_reg <= 1'b0;
            s1_re_reg    <= '0;
            s1_im_reg    <= '0;
            s1_sh_re_reg <= '0;
            s1_sh_im_reg <= '0;
        end else begin
            s1_valid_reg <= accept;
            s1_start_reg <= accept & blk_start_in;
            if (accept) begin
                s1_re_reg    <= din_re;
                s1_im_reg    <= din_im;
                s1_sh_re_reg <= calc_sh(cur_idx_re);
                s1_sh_im_reg <= calc_sh(cur_idx_im);
            end
        end
    end

    // ---------------- lane shifters ----------------
    dout_arr_t             res_re, res_im;
    logic [ARRAY_SIZE-1:0] sat_re, sat_im;

    for (genvar gi = 0; gi < ARRAY_SIZE; gi++) begin : g_lane
        cbfp_lane_shift u_re (
            .din   (s1_re_reg[gi]),
            .sh    (s1_sh_re_reg),
            .value (res_re[gi]),
            .sat   (sat_re[gi])
        );
        cbfp_lane_shift u_im (
            .din   (s1_im_reg[gi]),
            .sh    (s1_sh_im_reg),
            .value (res_im[gi]),
            .sat   (sat_im[gi])
        );
    end

    // ---------------- stage 2: results ----------------
    logic      valid_out_reg;
    logic      blk_start_out_reg;
    logic      sat_out_reg;
    logic      err_frame_reg;
    dout_arr_t dout_re_reg, dout_im_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_out_reg     <= 1'b0;
            blk_start_out_reg <= 1'b0;
            sat_out_reg       <= 1'b0;
            err_frame_reg     <= 1'b0;
            dout_re_reg       <= '0;
            dout_im_reg       <= '0;
        end else begin
            valid_out_reg     <= s1_valid_reg;
            blk_start_out_reg <= s1_valid_reg & s1_start_reg;
            sat_out_reg       <= s1_valid_reg & ((|sat_re) | (|sat_im));
            err_frame_reg     <= err_next;
            if (s1_valid_reg) begin
                dout_re_reg <= res_re;
                dout_im_reg <= res_im;
            end
        end
    end

    assign valid_out     = valid_out_reg;
    assign blk_start_out = blk_start_out_reg;
    assign sat_out       = sat_out_reg;
    assign err_frame     = err_frame_reg;
    assign dout_re       = dout_re_reg;
    assign dout_im       = dout_im_reg;

endmodule

// File: tb/tb_cbfp_denorm.sv
module tb_cbfp_denorm;
    import cbfp_pkg::*;

    localparam int N      = 1024;   // cycles recorded
    localparam int REF_SH = 6;
    localparam int BEATS  = 4;
    localparam int LANES  = 16;

    logic      clk = 1'b0;
    logic      rst;
    logic      valid_in, blk_start_in;
    idx_t      idx_re_in, idx_im_in;
    mant_arr_t din_re, din_im;
    logic      valid_out, blk_start_out, sat_out, err_frame;
    dout_arr_t dout_re, dout_im;

    cbfp_denorm dut (
        .clk           (clk),
        .rst           (rst),
        .valid_in      (valid_in),
        .blk_start_in  (blk_start_in),
        .idx_re_in     (idx_re_in),
        .idx_im_in     (idx_im_in),
        .din_re        (din_re),
        .din_im        (din_im),
        .valid_out     (valid_out),
        .blk_start_out (blk_start_out),
        .dout_re       (dout_re),
        .dout_im       (dout_im),
        .sat_out       (sat_out),
        .err_frame     (err_frame)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors     = 0;
    int miscompares = 0;

    // Observed outputs per cycle, captured mid-cycle.
    logic      obs_valid[N], obs_start[N], obs_sat[N], obs_err[N];
    dout_arr_t obs_re[N], obs_im[N];
    // Expected outputs per cycle, written by the reference model.
    logic      exp_valid[N], exp_start[N], exp_sat[N], exp_err[N];
    dout_arr_t exp_re[N], exp_im[N];

    always @(negedge clk) begin
        if (cyc < N) begin
            obs_valid[cyc] = valid_out;
            obs_start[cyc] = blk_start_out;
            obs_sat[cyc]   = sat_out;
            obs_err[cyc]   = err_frame;
            obs_re[cyc]    = dout_re;
            obs_im[cyc]    = dout_im;
        end
    end

    // ---------------- reference model ----------------
    bit m_in_blk = 0;
    int m_pos    = 0;
    int m_idx_re = 0;
    int m_idx_im = 0;

    // Value of mantissa m scaled by 2^(REF_SH - idx), clipped to 16 bits.
    function automatic int ref_lane(input int m, input int idx, output bit sat);
        int     sh;
        longint v, d, x;
        sh = REF_SH - idx;
        if (sh >= 0) begin
            v = longint'(m) * (longint'(1) << sh);
        end else begin
            d = longint'(1) << (-sh);
`ifdef CBFP_DENORM_ROUND_EN
            x = longint'(m) + d / 2;
`else
            x = longint'(m);
`endif
            v = x / d;
            if ((x % d != 0) && (x < 0)) v = v - 1;   // floor division
        end
        sat = 1'b0;
        if (v > 32767) begin
            v = 32767;
            sat = 1'b1;
        end else if (v < -32768) begin
            v = -32768;
            sat = 1'b1;
        end
        return int'(v);
    endfunction

    // Applies one input cycle and records what the DUT must produce.
    // The error pulse is expected 1 cycle later and the output beat 2 cycles later.
    task automatic drive(input bit v, input bit s, input int ire, input int iim,
                         input mant_arr_t re, input mant_arr_t im);
        int n;
        bit acc, err, sr, si, sat_any;
        int val;
        valid_in     = v;
        blk_start_in = s;
        idx_re_in    = idx_t'(ire);
        idx_im_in    = idx_t'(iim);
        din_re       = re;
        din_im       = im;
        rst          = 1'b0;
        n   = cyc + 1;
        acc = 0;
        err = 0;
        if (v) begin
            if (s) begin
                err      = m_in_blk;
                m_in_blk = (BEATS > 1);
                m_pos    = 1;
                m_idx_re = ire;
                m_idx_im = iim;
                acc      = 1;
            end else if (m_in_blk) begin
                acc   = 1;
                m_pos = m_pos + 1;
                if (m_pos == BEATS) m_in_blk = 0;
            end else begin
                err = 1;
            end
        end
        if (n < N) exp_err[n] = err;
        if (acc && (n + 1 < N)) begin
            sat_any = 0;
            for (int l = 0; l < LANES; l++) begin
                val = ref_lane($signed(re[l]), m_idx_re, sr);
                exp_re[n+1][l] = 16'(val);
                val = ref_lane($signed(im[l]), m_idx_im, si);
                exp_im[n+1][l] = 16'(val);
                sat_any = sat_any | sr | si;
            end
            exp_valid[n+1] = 1'b1;
            exp_start[n+1] = s;
            exp_sat[n+1]   = sat_any;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive_rst();
        int n;
        rst      = 1'b1;
        valid_in = 1'b0;
        blk_start_in = 1'b0;
        n = cyc + 1;
        m_in_blk = 0;
        m_pos    = 0;
        m_idx_re = 0;
        m_idx_im = 0;
        for (int k = 0; k < 2; k++) begin
            if (n + k < N) begin
                exp_valid[n+k] = 1'b0;
                exp_start[n+k] = 1'b0;
                exp_sat[n+k]   = 1'b0;
                exp_err[n+k]   = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) drive(0, 0, 0, 0, '0, '0);
    endtask

    function automatic mant_arr_t rand_mant(input int lim);
        mant_arr_t a;
        for (int l = 0; l < LANES; l++) begin
            if (lim <= 0) a[l] = 11'($urandom);
            else a[l] = 11'(int'($urandom_range(0, 2 * lim)) - lim);
        end
        return a;
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        drive_rst();
        drive_rst();
        drive_rst();
        idle(1);
        vectors++;
        if ({obs_valid[cyc-1], obs_start[cyc-1], obs_sat[cyc-1], obs_err[cyc-1]} !== 4'b0000 ||
            obs_re[cyc-1] !== '0 || obs_im[cyc-1] !== '0) begin
            miscompares++;
            $display("FAIL reset_state: got v/s/sat/err=%b%b%b%b re=%h im=%h, required all zero",
                     obs_valid[cyc-1], obs_start[cyc-1], obs_sat[cyc-1], obs_err[cyc-1],
                     obs_re[cyc-1], obs_im[cyc-1]);
        end
    endtask

    task automatic test_scaling();
        int c0, ca, cb, cc;
        mant_arr_t re, im;
        logic [15:0] e;
        c0 = cyc;
        // Block A: idx_re=2 gives x16, and idx_im=6 gives unity.
        re = rand_mant(1023); im = rand_mant(1023);
        re[0] = 11'd100; im[0] = 11'(-5);
        ca = cyc + 2;
        drive(1, 1, 2, 6, re, im);
        for (int b = 1; b < BEATS; b++) drive(1, 0, 31, 31, rand_mant(1023), rand_mant(1023));
        // Block B: idx=8 gives a right shift by 2.
        re = rand_mant(1023); im = rand_mant(1023);
        re[0] = 11'd103; re[1] = 11'(-103); im[0] = 11'(-103);
        cb = cyc + 2;
        drive(1, 1, 8, 8, re, im);
        for (int b = 1; b < BEATS; b++) drive(1, 0, 0, 0, rand_mant(1023), rand_mant(1023));
        // Block C: idx=0 gives x64. Beat 0 clips and beat 1 stays in range.
        re = '0; im = '0;
        re[0] = 11'd1023; im[3] = 11'(-1024);
        cc = cyc + 2;
        drive(1, 1, 0, 0, re, im);
        drive(1, 0, 5, 5, rand_mant(511), rand_mant(511));
        drive(1, 0, 5, 5, rand_mant(0), rand_mant(0));
        drive(1, 0, 5, 5, rand_mant(0), rand_mant(0));
        idle(3);

        vectors++;
        if (obs_re[ca][0] !== 16'd1600) begin
            miscompares++;
            $display("FAIL unity_scale_re: got %0d required 1600", $signed(obs_re[ca][0]));
        end
        e = 16'(-5);
        vectors++;
        if (obs_im[ca][0] !== e) begin
            miscompares++;
            $display("FAIL unity_im: got %0d required -5", $signed(obs_im[ca][0]));
        end
`ifdef CBFP_DENORM_ROUND_EN
        e = 16'd26;
`else
        e = 16'd25;
`endif
        vectors++;
        if (obs_re[cb][0] !== e) begin
            miscompares++;
            $display("FAIL rshift_pos: got %0d required %0d", $signed(obs_re[cb][0]), $signed(e));
        end
        e = 16'(-26);
        vectors++;
        if (obs_re[cb][1] !== e || obs_im[cb][0] !== e) begin
            miscompares++;
            $display("FAIL rshift_neg: got %0d/%0d required -26", $signed(obs_re[cb][1]), $signed(obs_im[cb][0]));
        end
        vectors++;
        if ({obs_start[cb], obs_start[cb+1]} !== 2'b10) begin
            miscompares++;
            $display("FAIL start_first_only: got %b required 10", {obs_start[cb], obs_start[cb+1]});
        end
        e = 16'(-32768);
        vectors++;
        if (obs_re[cc][0] !== 16'd32767 || obs_im[cc][3] !== e || obs_sat[cc] !== 1'b1) begin
            miscompares++;
            $display("FAIL saturate: got re=%0d im=%0d sat=%b required 32767 -32768 1",
                     $signed(obs_re[cc][0]), $signed(obs_im[cc][3]), obs_sat[cc]);
        end
        vectors++;
        if (obs_sat[cc+1] !== 1'b0) begin
            miscompares++;
            $display("FAIL no_sat: got %b required 0", obs_sat[cc+1]);
        end

        for (int c = c0 + 1; c < cyc; c++) begin
            vectors++;
            if ({obs_valid[c], obs_start[c], obs_sat[c], obs_err[c]} !==
                {exp_valid[c], exp_start[c], exp_sat[c], exp_err[c]}) begin
                miscompares++;
                $display("FAIL scaling_ctrl cyc %0d: got v/s/sat/err=%b%b%b%b required %b%b%b%b", c,
                         obs_valid[c], obs_start[c], obs_sat[c], obs_err[c],
                         exp_valid[c], exp_start[c], exp_sat[c], exp_err[c]);
            end
            if (exp_valid[c]) begin
                vectors++;
                if (obs_re[c] !== exp_re[c] || obs_im[c] !== exp_im[c]) begin
                    miscompares++;
                    $display("FAIL scaling_data cyc %0d: got re=%h im=%h required re=%h im=%h",
                             c, obs_re[c], obs_im[c], exp_re[c], exp_im[c]);
                end
            end
        end
    endtask

    task automatic test_gaps();
        int c0, nv;
        c0 = cyc;
        // Junk indices on non-start beats must be ignored.
        drive(1, 1, 3, 9, rand_mant(0), rand_mant(0));
        for (int b = 1; b < BEATS; b++) drive(1, 0, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), rand_mant(0), rand_mant(0));
        idle(4);
        drive(1, 1, 7, 4, rand_mant(0), rand_mant(0));
        drive(1, 0, 31, 0, rand_mant(0), rand_mant(0));
        idle(3);
        drive(1, 0, 0, 31, rand_mant(0), rand_mant(0));
        drive(1, 0, 12, 12, rand_mant(0), rand_mant(0));
        idle(3);
        nv = 0;
        for (int c = c0 + 1; c < cyc; c++) begin
            if (obs_valid[c] === 1'b1) nv++;
            vectors++;
            if ({obs_valid[c], obs_start[c], obs_sat[c], obs_err[c]} !==
                {exp_valid[c], exp_start[c], exp_sat[c], exp_err[c]}) begin
                miscompares++;
                $display("FAIL gaps_ctrl cyc %0d: got v/s/sat/err=%b%b%b%b required %b%b%b%b", c,
                         obs_valid[c], obs_start[c], obs_sat[c], obs_err[c],
                         exp_valid[c], exp_start[c], exp_sat[c], exp_err[c]);
            end
            if (exp_valid[c]) begin
                vectors++;
                if (obs_re[c] !== exp_re[c] || obs_im[c] !== exp_im[c]) begin
                    miscompares++;
                    $display("FAIL gaps_data cyc %0d: got re=%h im=%h required re=%h im=%h",
                             c, obs_re[c], obs_im[c], exp_re[c], exp_im[c]);
                end
            end
        end
        vectors++;
        if (nv != 8) begin
            miscompares++;
            $display("FAIL gaps_beat_count: got %0d required 8", nv);
        end
    endtask

    task automatic test_errors();
        int c0, ce, cr;
        c0 = cyc;
        ce = cyc + 1;
        drive(1, 0, 1, 1, rand_mant(0), rand_mant(0));   // orphan beat in IDLE
        idle(2);
        drive(1, 1, 3, 9, rand_mant(0), rand_mant(0));
        drive(1, 0, 0, 0, rand_mant(0), rand_mant(0));
        cr = cyc + 1;
        drive(1, 1, 10, 1, rand_mant(0), rand_mant(0));  // restart on beat 2
        for (int b = 1; b < BEATS; b++) drive(1, 0, 0, 0, rand_mant(0), rand_mant(0));
        idle(3);
        vectors++;
        if (obs_err[ce] !== 1'b1 || obs_valid[ce+1] !== 1'b0) begin
            miscompares++;
            $display("FAIL orphan_beat: got err=%b valid=%b required err=1 valid=0", obs_err[ce], obs_valid[ce+1]);
        end
        vectors++;
        if (obs_err[cr] !== 1'b1 || obs_start[cr+1] !== 1'b1) begin
            miscompares++;
            $display("FAIL restart_err: got err=%b start=%b required 1 1", obs_err[cr], obs_start[cr+1]);
        end
        for (int c = c0 + 1; c < cyc; c++) begin
            vectors++;
            if ({obs_valid[c], obs_start[c], obs_sat[c], obs_err[c]} !==
                {exp_valid[c], exp_start[c], exp_sat[c], exp_err[c]}) begin
                miscompares++;
                $display("FAIL errors_ctrl cyc %0d: got v/s/sat/err=%b%b%b%b required %b%b%b%b", c,
                         obs_valid[c], obs_start[c], obs_sat[c], obs_err[c],
                         exp_valid[c], exp_start[c], exp_sat[c], exp_err[c]);
            end
            if (exp_valid[c]) begin
                vectors++;
                if (obs_re[c] !== exp_re[c] || obs_im[c] !== exp_im[c]) begin
                    miscompares++;
                    $display("FAIL errors_data cyc %0d: got re=%h im=%h required re=%h im=%h",
                             c, obs_re[c], obs_im[c], exp_re[c], exp_im[c]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_block();
        int r, ce;
        drive(1, 1, 0, 0, rand_mant(0), rand_mant(0));
        drive(1, 0, 0, 0, rand_mant(0), rand_mant(0));
        r = cyc + 1;
        drive_rst();
        idle(1);
        vectors++;
        if ({obs_valid[r], obs_start[r], obs_sat[r], obs_err[r]} !== 4'b0000 ||
            obs_re[r] !== '0 || obs_im[r] !== '0) begin
            miscompares++;
            $display("FAIL reset_mid_block: got v/s/sat/err=%b%b%b%b re=%h im=%h required all zero",
                     obs_valid[r], obs_start[r], obs_sat[r], obs_err[r], obs_re[r], obs_im[r]);
        end
        vectors++;
        if (obs_valid[r+1] !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_flush: got valid=%b required 0", obs_valid[r+1]);
        end
        ce = cyc + 1;
        drive(1, 0, 0, 0, rand_mant(0), rand_mant(0));
        idle(3);
        vectors++;
        if (obs_err[ce] !== 1'b1 || obs_valid[ce+1] !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_to_idle: got err=%b valid=%b required err=1 valid=0", obs_err[ce], obs_valid[ce+1]);
        end
    endtask

    task automatic test_random();
        int c0;
        bit v, s;
        c0 = cyc;
        for (int i = 0; i < 300; i++) begin
            v = ($urandom_range(0, 3) != 0);
            if (m_in_blk) s = ($urandom_range(0, 15) == 0);
            else s = ($urandom_range(0, 7) != 0);
            drive(v, s, int'($urandom_range(0, ($urandom_range(0, 3) == 0) ? 31 : 12)),
                  int'($urandom_range(0, ($urandom_range(0, 3) == 0) ? 31 : 12)),
                  rand_mant(0), rand_mant(0));
        end
        idle(3);
        for (int c = c0 + 1; c < cyc; c++) begin
            vectors++;
            if ({obs_valid[c], obs_start[c], obs_sat[c], obs_err[c]} !==
                {exp_valid[c], exp_start[c], exp_sat[c], exp_err[c]}) begin
                miscompares++;
                $display("FAIL random_ctrl cyc %0d: got v/s/sat/err=%b%b%b%b required %b%b%b%b", c,
                         obs_valid[c], obs_start[c], obs_sat[c], obs_err[c],
                         exp_valid[c], exp_start[c], exp_sat[c], exp_err[c]);
            end
            if (exp_valid[c]) begin
                vectors++;
                if (obs_re[c] !== exp_re[c] || obs_im[c] !== exp_im[c]) begin
                    miscompares++;
                    $display("FAIL random_data cyc %0d: got re=%h im=%h required re=%h im=%h",
                             c, obs_re[c], obs_im[c], exp_re[c], exp_im[c]);
                end
            end
        end
    endtask

    initial begin
        for (int c = 0; c < N; c++) begin
            exp_valid[c] = 1'b0;
            exp_start[c] = 1'b0;
            exp_sat[c]   = 1'b0;
            exp_err[c]   = 1'b0;
            exp_re[c]    = '0;
            exp_im[c]    = '0;
        end
        rst          = 1'b1;
        valid_in     = 1'b0;
        blk_start_in = 1'b0;
        idx_re_in    = '0;
        idx_im_in    = '0;
        din_re       = '0;
        din_im       = '0;

        test_reset();
        test_scaling();
        test_gaps();
        test_errors();
        test_reset_mid_block();
        test_random();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cbfp_denorm.md
Name: cbfp_denorm

Overview:
- Output-side counterpart of the CBFP normaliser.
- Accepts 16-lane re/im mantissa beats (11-bit) plus the per-block scaling index produced by the normaliser, and restores every sample to a common fixed-point scale, 16-bit wide.
- Sits after the last CBFP stage and before the FFT output reorder / host interface.
- Frames blocks of 4 beats (64 samples) and tracks the block index across valid gaps.

Parameters:
- CNT_SIZE, 5: width of scaling index (zero count).
- ARRAY_SIZE, 16: lanes per beat.
- DIN_SIZE, 11: input mantissa width, signed.
- DOUT_SIZE, 16: output width, signed.
- BEATS_PER_BLK, 4: valid beats per CBFP block.
- SHIFT_REF, 6: index value that maps to unity gain.

Ports:
- clk, in, 1: clock.
- rst, in, 1: synchronous reset, active-high.
- valid_in, in, 1: input beat valid.
- blk_start_in, in, 1: first beat of a block; qualified by valid_in.
- idx_re_in, in, CNT_SIZE: block index for real part; sampled on the start beat.
- idx_im_in, in, CNT_SIZE: block index for imag part; sampled on the start beat.
- din_re, in, DIN_SIZE x ARRAY_SIZE: real mantissas.
- din_im, in, DIN_SIZE x ARRAY_SIZE: imag mantissas.
- valid_out, out, 1: output beat valid.
- blk_start_out, out, 1: first output beat of a block.
- dout_re, out, DOUT_SIZE x ARRAY_SIZE: denormalised real.
- dout_im, out, DOUT_SIZE x ARRAY_SIZE: denormalised imag.
- sat_out, out, 1: some lane of this output beat saturated.
- err_frame, out, 1: one-cycle framing-error pulse.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - valid_out, blk_start_out, sat_out, err_frame, all dout lanes go to 0.
  - FSM goes to IDLE; beat_cnt and latched indices go to 0.
  - The pipeline is flushed, so any in-flight beats are discarded.
- FSM states: IDLE and IN_BLK. beat_cnt is 0..BEATS_PER_BLK-1 and advances only on valid_in=1.
- IDLE transitions:
  - valid_in & blk_start_in: latch idx_re/idx_im, beat_cnt=1, go to IN_BLK. If BEATS_PER_BLK=1, stay in IDLE.
  - valid_in & !blk_start_in: err_frame pulses and the beat is dropped (no valid_out).
- IN_BLK transitions:
  - valid_in & !blk_start_in: beat_cnt++. On the beat where beat_cnt reaches BEATS_PER_BLK-1 (last beat), return to IDLE.
  - valid_in & blk_start_in: err_frame pulses. The current block is abandoned and the new block restarts with fresh indices, beat_cnt=1. That start beat is processed normally.
  - valid_in=0: hold state and indices. Gaps of any length are allowed mid-block.
- Per lane shift amount: sh = SHIFT_REF - idx, signed, CNT_SIZE+1 bits. Use idx_re for re lanes, idx_im for im lanes.
- Arithmetic:
  - sh>=0: sign-extend the mantissa, shift left by sh, then saturate to [-2^(DOUT_SIZE-1), 2^(DOUT_SIZE-1)-1].
  - sh<0: arithmetic right shift by -sh (floor). If -sh>=DIN_SIZE, the result is 0 or -1 by sign.
- sat_out = OR of the saturation detect across all 32 lanes of the beat.
- Pipeline and latency:
  - Stage 1 registers mantissas, sh values, and the start flag.
  - Stage 2 registers shift/saturate results.
  - Fixed latency of 2 cycles from an accepted valid_in beat to valid_out.
  - Throughput is 1 beat/cycle, with no back-pressure.
- Start-beat index use: on the start beat, the freshly sampled indices are used for that same beat, not the previously latched ones.
- blk_start_out follows the accepted start beat by 2 cycles.

Optional Feature:
- Macro: CBFP_DENORM_ROUND_EN.
- Defined: right shifts round half-up by adding 2^(-sh-1) before shifting. A rounding overflow saturates like any other overflow.
- Undefined: plain truncating arithmetic shift (floor).
- Left shifts are identical in both builds.

Decomposition:
- Package cbfp_pkg holds:
  - Default widths: CNT_SIZE, DIN_SIZE, DOUT_SIZE, ARRAY_SIZE, BEATS_PER_BLK.
  - typedefs for the mantissa lane array, output lane array, and index type.
  - The FSM enum {IDLE, IN_BLK}.
- Sub-module cbfp_lane_shift: combinational single-lane shift/round/saturate with outputs value and sat. Instantiated 2*ARRAY_SIZE times.
- The framing FSM and pipeline registers live in the top level.

Test Plan:
- Unity and scaling: block with idx_re=2 and lane 0 re=100 -> dout_re[0]=1600 two cycles later. idx_im=6 with im=-5 -> dout_im=-5.
- Right shift: idx=8 with mantissa 103 -> 25 without the macro, 26 with it. Mantissa -103 -> -26 in both builds. blk_start_out asserts on the first beat only.
- Saturation: idx=0 with 1023 -> 32767 and sat_out=1. Same beat with -1024 on a lane -> -32768. sat_out stays 0 on beats without overflow.
- Framing across gaps: 4 valid beats, 4 idle cycles, 4 beats (sequence as in the normaliser bench) -> 8 valid_out beats in the same pattern, indices held through the gap, err_frame never asserts.
- Errors: valid_in without blk_start_in in IDLE -> err_frame pulse and no valid_out. blk_start_in on beat 2 of a block -> err_frame pulse and the new block's indices are applied from that beat.
- Reset mid-block: rst asserted after 2 beats -> next cycle all outputs are 0. A subsequent non-start beat -> err_frame, proving the FSM is in IDLE.
